// File: rtl/dff_pr_clr.sv
// rtl/dff_pr_clr.sv - D register with async active-low clear, sync preset, clock enable, complementary outputs
module dff_pr_clr #(
  parameter int                 WIDTH      = 1,
  parameter logic [WIDTH-1:0]   PRESET_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             pr,
  input  logic             en,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn
);

  logic [WIDTH-1:0] r_q;

  // Clear beats preset, preset beats enable; a held clear blocks every capture.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_q <= '0;
    end else if (pr) begin
      r_q <= PRESET_VAL;
    end else if (en) begin
      r_q <= D;
    end
  end

  assign Q  = r_q;
  assign Qn = ~r_q;

endmodule

// File: tb/tb_dff_pr_clr.sv
// tb/tb_dff_pr_clr.sv - self-checking bench for dff_pr_clr (1-bit and 8-bit instances)
module tb_dff_pr_clr;

  logic       clk = 1'b0;
  logic       clr_n;
  logic       pr;
  logic       en;
  logic       d1;
  logic       q1;
  logic       qn1;
  logic [7:0] d8;
  logic [7:0] q8;
  logic [7:0] qn8;

  int errors = 0;
  int checks = 0;

  always #10 clk = ~clk;

  dff_pr_clr #(.WIDTH(1)) u_dut1 (
    .clk   (clk),
    .clr_n (clr_n),
    .pr    (pr),
    .en    (en),
    .D     (d1),
    .Q     (q1),
    .Qn    (qn1)
  );

  dff_pr_clr #(.WIDTH(8), .PRESET_VAL(8'hA5)) u_dut8 (
    .clk   (clk),
    .clr_n (clr_n),
    .pr    (pr),
    .en    (en),
    .D     (d8),
    .Q     (q8),
    .Qn    (qn8)
  );

  task automatic test_reset();
    clr_n = 1'b0; pr = 1'b0; en = 1'b1; d1 = 1'b1; d8 = 8'hFF;
    #1;
    checks++;
    if (q1 !== 1'b0 || qn1 !== 1'b1) begin
      errors++;
      $display("FAIL reset_immediate q=%b qn=%b expected q=0 qn=1", q1, qn1);
    end
    checks++;
    if (q8 !== 8'h00 || qn8 !== 8'hFF) begin
      errors++;
      $display("FAIL reset_immediate_w8 q=%h qn=%h expected q=00 qn=ff", q8, qn8);
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if (q1 !== 1'b0 || qn1 !== 1'b1) begin
        errors++;
        $display("FAIL reset_hold_edge%0d q=%b qn=%b expected q=0 qn=1", i, q1, qn1);
      end
    end
  endtask

  task automatic test_preset();
    @(negedge clk);
    clr_n = 1'b1; pr = 1'b1; d1 = 1'b0; d8 = 8'h00;
    @(posedge clk); #1;
    checks++;
    if (q1 !== 1'b1 || qn1 !== 1'b0) begin
      errors++;
      $display("FAIL preset q=%b qn=%b expected q=1 qn=0", q1, qn1);
    end
    checks++;
    if (q8 !== 8'hA5 || qn8 !== 8'h5A) begin
      errors++;
      $display("FAIL preset_w8 q=%h qn=%h expected q=a5 qn=5a", q8, qn8);
    end
    @(negedge clk);
    clr_n = 1'b0;
    #1;
    checks++;
    if (q1 !== 1'b0 || qn1 !== 1'b1) begin
      errors++;
      $display("FAIL clear_beats_preset q=%b qn=%b expected q=0 qn=1", q1, qn1);
    end
    @(posedge clk); #1;
    checks++;
    if (q1 !== 1'b0 || q8 !== 8'h00) begin
      errors++;
      $display("FAIL clear_beats_preset_edge q=%b q8=%h expected q=0 q8=00", q1, q8);
    end
  endtask

  task automatic test_capture();
    @(negedge clk);
    clr_n = 1'b1; pr = 1'b0; en = 1'b1; d1 = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (q1 !== 1'b0 || qn1 !== 1'b1) begin
      errors++;
      $display("FAIL capture_0 q=%b qn=%b expected q=0 qn=1", q1, qn1);
    end
    @(negedge clk);
    d1 = 1'b1;
    #1;
    checks++;
    if (q1 !== 1'b0) begin
      errors++;
      $display("FAIL capture_latency q=%b expected 0 before edge", q1);
    end
    @(posedge clk); #1;
    checks++;
    if (q1 !== 1'b1 || qn1 !== 1'b0) begin
      errors++;
      $display("FAIL capture_1 q=%b qn=%b expected q=1 qn=0", q1, qn1);
    end
  endtask

  task automatic test_enable_hold();
    @(negedge clk);
    en = 1'b0; d1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (q1 !== 1'b1 || qn1 !== 1'b0) begin
        errors++;
        $display("FAIL enable_hold_edge%0d q=%b qn=%b expected q=1 qn=0", i, q1, qn1);
      end
    end
    @(negedge clk);
    en = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (q1 !== 1'b0 || qn1 !== 1'b1) begin
      errors++;
      $display("FAIL enable_release q=%b qn=%b expected q=0 qn=1", q1, qn1);
    end
  endtask

  task automatic test_async_mid();
    @(negedge clk);
    d1 = 1'b1; en = 1'b1; pr = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (q1 !== 1'b1) begin
      errors++;
      $display("FAIL async_setup q=%b expected 1", q1);
    end
    #4;
    clr_n = 1'b0;
    #1;
    checks++;
    if (q1 !== 1'b0 || qn1 !== 1'b1) begin
      errors++;
      $display("FAIL async_mid_clear q=%b qn=%b expected q=0 qn=1", q1, qn1);
    end
    @(negedge clk);
    clr_n = 1'b1; d1 = 1'b1;
    #1;
    checks++;
    if (q1 !== 1'b0) begin
      errors++;
      $display("FAIL async_release_no_capture q=%b expected 0", q1);
    end
    @(posedge clk); #1;
    checks++;
    if (q1 !== 1'b1 || qn1 !== 1'b0) begin
      errors++;
      $display("FAIL async_release_capture q=%b qn=%b expected q=1 qn=0", q1, qn1);
    end
  endtask

  task automatic test_width8();
    @(negedge clk);
    clr_n = 1'b1; pr = 1'b1; en = 1'b0; d8 = 8'h00;
    @(posedge clk); #1;
    checks++;
    if (q8 !== 8'hA5 || qn8 !== 8'h5A) begin
      errors++;
      $display("FAIL width8_preset q=%h qn=%h expected q=a5 qn=5a", q8, qn8);
    end
    @(negedge clk);
    pr = 1'b0; en = 1'b1; d8 = 8'h3C;
    @(posedge clk); #1;
    checks++;
    if (q8 !== 8'h3C || qn8 !== 8'hC3) begin
      errors++;
      $display("FAIL width8_capture q=%h qn=%h expected q=3c qn=c3", q8, qn8);
    end
  endtask

  // Reference: Q is a stored value updated by the priority rules clear > preset > enable > hold.
  task automatic test_random();
    logic       m1;
    logic [7:0] m8;
    @(negedge clk);
    clr_n = 1'b0;
    m1 = 1'b0; m8 = 8'h00;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      clr_n = ($urandom_range(0, 15) != 0);
      pr    = ($urandom_range(0, 7) == 0);
      en    = $urandom_range(0, 1) == 1;
      d1    = $urandom_range(0, 1) == 1;
      d8    = 8'($urandom_range(0, 255));
      #1;
      if (!clr_n) begin
        m1 = 1'b0; m8 = 8'h00;
      end
      checks++;
      if (q1 !== m1 || qn1 !== ~m1 || q8 !== m8 || qn8 !== ~m8) begin
        errors++;
        $display("FAIL random_pre_edge%0d q1=%b qn1=%b q8=%h qn8=%h expected q1=%b q8=%h", i, q1, qn1, q8, qn8, m1, m8);
      end
      if (clr_n) begin
        if (pr) begin
          m1 = 1'b1; m8 = 8'hA5;
        end else if (en) begin
          m1 = d1; m8 = d8;
        end
      end
      @(posedge clk); #1;
      checks++;
      if (q1 !== m1 || qn1 !== ~m1 || q8 !== m8 || qn8 !== ~m8) begin
        errors++;
        $display("FAIL random_edge%0d q1=%b qn1=%b q8=%h qn8=%h expected q1=%b q8=%h", i, q1, qn1, q8, qn8, m1, m8);
      end
    end
  endtask

  initial begin
    test_reset();
    test_preset();
    test_capture();
    test_enable_hold();
    test_async_mid();
    test_width8();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
